vga_scaler_pipe: RTL and testbench

- Parametrised successor to the fixed 2x VGA upscaler.
- Maps VGA timing coordinates onto a SRC_W x SRC_H RGB565 framebuffer.
- Selectable integer scale (1x/2x/4x), optional window centering with a border colour, and RGB or grayscale output.
- Sits between vga_control and the framebuffer read port on the VGA clock; drives the physical VGA pins.

---
 rtl/vga_scaler_pipe.sv | 193 +++++++++++++++++++
 tb/tb_vga_scaler_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaler_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vga_scaler_pipe: VGA coordinates -> scaled/centred RGB565 fetch + out |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module vga_scaler_pipe #(
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 17,
  parameter int RD_LAT   = 1,
  parameter int OUT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              x_pixel,
  input  logic [9:0]              y_pixel,
  input  logic                    data_enable,
  input  logic                    VGAHS_in,
  input  logic                    VGAVS_in,
  input  logic [1:0]              scale_sel,
  input  logic                    center_en,
  input  logic                    gray_en,
  input  logic [3*OUT_BITS-1:0]   border_rgb,
  output logic                    fb_rd_en,
  output logic [ADDR_W-1:0]       fb_rd_addr,
  input  logic [15:0]             fb_pixel,
  output logic [OUT_BITS-1:0]     VGA_R,
  output logic [OUT_BITS-1:0]     VGA_G,
  output logic [OUT_BITS-1:0]     VGA_B,
  output logic                    VGAHS,
  output logic                    VGAVS,
  output logic [1:0]              scale_active
);

  // Largest shift whose window still fits the active area.
  localparam logic [1:0] c_max_s =
    ((SRC_W * 4 <= H_ACTIVE) && (SRC_H * 4 <= V_ACTIVE)) ? 2'd2 :
    ((SRC_W * 2 <= H_ACTIVE) && (SRC_H * 2 <= V_ACTIVE)) ? 2'd1 : 2'd0;
  // Side-band depth up to the output register: stage 1 plus the read latency.
  localparam int c_side_depth = RD_LAT + 1;

  logic        r_vs_d;
  logic [1:0]  r_scale;
  logic        r_center;
  logic        r_gray;
  logic        w_vs_fall;
  logic [1:0]  w_req_s;
  logic [1:0]  w_eff_s;

  assign w_vs_fall = r_vs_d & ~VGAVS_in;

  always_comb begin
    w_req_s = 2'd0;
    case (scale_sel)
      2'd1:    w_req_s = 2'd1;
      2'd2:    w_req_s = 2'd2;
      default: w_req_s = 2'd0;
    endcase
    w_eff_s = (w_req_s > c_max_s) ? c_max_s : w_req_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d   <= 1'b1;
      r_scale  <= 2'd0;
      r_center <= 1'b0;
      r_gray   <= 1'b0;
    end else begin
      r_vs_d <= VGAVS_in;
      if (w_vs_fall) begin
        r_scale  <= w_eff_s;
        r_center <= center_en;
        r_gray   <= gray_en;
      end
    end
  end

  assign scale_active = r_scale;

  logic [11:0]       w_win_w;
  logic [11:0]       w_win_h;
  logic [11:0]       w_off_x;
  logic [11:0]       w_off_y;
  logic [11:0]       w_x;
  logic [11:0]       w_y;
  logic [11:0]       w_dx;
  logic [11:0]       w_dy;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_addr;

  // r_scale never exceeds c_max_s, so the offset subtraction cannot wrap.
  always_comb begin
    w_win_w  = 12'(SRC_W) << r_scale;
    w_win_h  = 12'(SRC_H) << r_scale;
    w_off_x  = r_center ? ((12'(H_ACTIVE) - w_win_w) >> 1) : 12'd0;
    w_off_y  = r_center ? ((12'(V_ACTIVE) - w_win_h) >> 1) : 12'd0;
    w_x      = {2'b00, x_pixel};
    w_y      = {2'b00, y_pixel};
    w_in_win = data_enable &&
               (w_x >= w_off_x) && (w_x < (w_off_x + w_win_w)) &&
               (w_y >= w_off_y) && (w_y < (w_off_y + w_win_h));
    w_dx     = (w_x - w_off_x) >> r_scale;
    w_dy     = (w_y - w_off_y) >> r_scale;
    w_addr   = ADDR_W'(w_dy) * ADDR_W'(SRC_W) + ADDR_W'(w_dx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
    end else begin
      fb_rd_en <= w_in_win;
      if (w_in_win) begin
        fb_rd_addr <= w_addr;
      end
    end
  end

  // Side-band bits {in_win, de, hs, vs} travel alongside the read.
  logic [3:0] r_side [c_side_depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_side_depth; i++) begin
        r_side[i] <= 4'b0011;
      end
    end else begin
      r_side[0] <= {w_in_win, data_enable, VGAHS_in, VGAVS_in};
      for (int i = 1; i < c_side_depth; i++) begin
        r_side[i] <= r_side[i-1];
      end
    end
  end

  logic [3:0]          w_tail;
  logic [5:0]          w_r6;
  logic [5:0]          w_g6;
  logic [5:0]          w_b6;
  logic [8:0]          w_y9;
  logic [OUT_BITS-1:0] w_gray;
  logic [OUT_BITS-1:0] w_r;
  logic [OUT_BITS-1:0] w_g;
  logic [OUT_BITS-1:0] w_b;

  assign w_tail = r_side[c_side_depth-1];
  assign w_r6   = {fb_pixel[15:11], fb_pixel[15]};
  assign w_g6   = fb_pixel[10:5];
  assign w_b6   = {fb_pixel[4:0], fb_pixel[4]};
  // Max sum is 8*63 = 504, so 9 bits never overflow.
  assign w_y9   = 9'({w_r6, 1'b0}) + 9'(w_g6) * 9'd5 + 9'(w_b6);
  assign w_gray = OUT_BITS'(w_y9 >> (9 - OUT_BITS));

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (!w_tail[2]) begin
      w_r = '0;
    end else if (!w_tail[3]) begin
      w_r = border_rgb[3*OUT_BITS-1 -: OUT_BITS];
      w_g = border_rgb[2*OUT_BITS-1 -: OUT_BITS];
      w_b = border_rgb[OUT_BITS-1:0];
    end else if (r_gray) begin
      w_r = w_gray;
      w_g = w_gray;
      w_b = w_gray;
    end else begin
      w_r = fb_pixel[15 -: OUT_BITS];
      w_g = fb_pixel[10 -: OUT_BITS];
      w_b = fb_pixel[4 -: OUT_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      VGAHS <= 1'b1;
      VGAVS <= 1'b1;
    end else begin
      VGA_R <= w_r;
      VGA_G <= w_g;
      VGA_B <= w_b;
      VGAHS <= w_tail[1];
      VGAVS <= w_tail[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scaler_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vga_scaler_pipe: directed checks for RD_LAT=1 and RD_LAT=3 copies  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_vga_scaler_pipe;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        data_enable;
  logic        VGAHS_in;
  logic        VGAVS_in;
  logic [1:0]  scale_sel;
  logic        center_en;
  logic        gray_en;
  logic [8:0]  border_rgb;

  logic        fb_rd_en,   fb_rd_en3;
  logic [16:0] fb_rd_addr, fb_rd_addr3;
  logic [15:0] fb_pixel,   fb_pixel3;
  logic [2:0]  VGA_R, VGA_G, VGA_B;
  logic [2:0]  VGA_R3, VGA_G3, VGA_B3;
  logic        VGAHS, VGAVS, VGAHS3, VGAVS3;
  logic [1:0]  scale_active, scale_active3;

  int checks;
  int failures;

  vga_scaler_pipe #(.RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data_enable(data_enable), .VGAHS_in(VGAHS_in), .VGAVS_in(VGAVS_in),
    .scale_sel(scale_sel), .center_en(center_en), .gray_en(gray_en),
    .border_rgb(border_rgb), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_pixel(fb_pixel), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGAHS(VGAHS), .VGAVS(VGAVS), .scale_active(scale_active)
  );

  vga_scaler_pipe #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data_enable(data_enable), .VGAHS_in(VGAHS_in), .VGAVS_in(VGAVS_in),
    .scale_sel(scale_sel), .center_en(center_en), .gray_en(gray_en),
    .border_rgb(border_rgb), .fb_rd_en(fb_rd_en3), .fb_rd_addr(fb_rd_addr3),
    .fb_pixel(fb_pixel3), .VGA_R(VGA_R3), .VGA_G(VGA_G3), .VGA_B(VGA_B3),
    .VGAHS(VGAHS3), .VGAVS(VGAVS3), .scale_active(scale_active3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [16:0] a);
    case (a)
      17'd0:   return 16'hF800;
      17'd1:   return 16'hFFFF;
      17'd2:   return 16'h07E0;
      default: return a[15:0];
    endcase
  endfunction

  // Framebuffer models: one-cycle and three-cycle read latency.
  logic [16:0] a3_q1, a3_q2;
  always @(posedge clk) begin
    fb_pixel  <= mem_val(fb_rd_addr);
    a3_q1     <= fb_rd_addr3;
    a3_q2     <= a3_q1;
    fb_pixel3 <= mem_val(a3_q2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_frame(input logic [1:0] s, input logic c, input logic g);
    scale_sel   = s;
    center_en   = c;
    gray_en     = g;
    data_enable = 1'b0;
    VGAVS_in    = 1'b0;
    step();
    VGAVS_in    = 1'b1;
    step();
  endtask

  task automatic pix(input int x, input int y);
    x_pixel     = 10'(x);
    y_pixel     = 10'(y);
    data_enable = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; x_pixel = '0; y_pixel = '0; data_enable = 1'b0;
    VGAHS_in = 1'b1; VGAVS_in = 1'b1; scale_sel = 2'd0; center_en = 1'b1;
    gray_en = 1'b0; border_rgb = 9'b101_010_011;
    hold(2);

    check("rst_r",       32'(VGA_R), 0);
    check("rst_hs",      32'(VGAHS), 1);
    check("rst_vs",      32'(VGAVS), 1);
    check("rst_rd_en",   32'(fb_rd_en), 0);
    check("rst_addr",    32'(fb_rd_addr), 0);
    check("rst_scale",   32'(scale_active), 0);
    check("rst_hs3",     32'(VGAHS3), 1);

    rst_n = 1'b1;
    step();
    new_frame(2'd0, 1'b1, 1'b0);
    check("scale_1x", 32'(scale_active), 0);

    // 1x centred: window origin at (160,120)
    pix(160, 120);
    step();
    check("c1x_en",   32'(fb_rd_en), 1);
    check("c1x_addr", 32'(fb_rd_addr), 0);
    hold(2);
    check("col_r", 32'(VGA_R), 7);
    check("col_g", 32'(VGA_G), 0);
    check("col_b", 32'(VGA_B), 0);
    hold(2);
    check("col_r3", 32'(VGA_R3), 7);

    pix(162, 120);
    hold(3);
    check("col_g_07e0", 32'(VGA_G), 7);
    check("col_r_07e0", 32'(VGA_R), 0);

    pix(479, 359);
    step();
    check("c1x_last_en",   32'(fb_rd_en), 1);
    check("c1x_last_addr", 32'(fb_rd_addr), 76799);

    pix(159, 120);
    step();
    check("left_en",   32'(fb_rd_en), 0);
    check("left_hold", 32'(fb_rd_addr), 76799);
    hold(2);
    check("border_r", 32'(VGA_R), 5);
    check("border_g", 32'(VGA_G), 2);
    check("border_b", 32'(VGA_B), 3);

    pix(480, 200);
    step();
    check("right_edge_en", 32'(fb_rd_en), 0);
    pix(160, 119);
    step();
    check("top_edge_en", 32'(fb_rd_en), 0);

    data_enable = 1'b0;
    x_pixel = 10'd200;
    hold(3);
    check("blank_r", 32'(VGA_R), 0);
    check("blank_g", 32'(VGA_G), 0);

    // 2x at origin
    new_frame(2'd1, 1'b0, 1'b0);
    check("scale_2x", 32'(scale_active), 1);
    pix(3, 5);
    step();
    check("s2_addr_a", 32'(fb_rd_addr), 641);
    pix(2, 4);
    step();
    check("s2_addr_b", 32'(fb_rd_addr), 641);
    pix(639, 479);
    step();
    check("s2_corner_en",   32'(fb_rd_en), 1);
    check("s2_corner_addr", 32'(fb_rd_addr), 76799);

    // 4x request clamps to 2x
    new_frame(2'd2, 1'b0, 1'b0);
    check("scale_4x_clamp", 32'(scale_active), 1);
    pix(3, 5);
    step();
    check("s4_addr", 32'(fb_rd_addr), 641);

    // Mid-frame scale change is ignored until the next VS fall
    new_frame(2'd0, 1'b0, 1'b0);
    pix(3, 5);
    step();
    check("mid_1x_addr", 32'(fb_rd_addr), 1603);
    scale_sel = 2'd1;
    hold(2);
    check("mid_still_1x", 32'(fb_rd_addr), 1603);
    check("mid_scale",    32'(scale_active), 0);
    new_frame(2'd1, 1'b0, 1'b0);
    pix(3, 5);
    step();
    check("mid_now_2x", 32'(fb_rd_addr), 641);

    // Grayscale, centred 1x
    new_frame(2'd0, 1'b1, 1'b1);
    pix(161, 120);
    hold(3);
    check("gray_ffff_r", 32'(VGA_R), 7);
    check("gray_ffff_g", 32'(VGA_G), 7);
    check("gray_ffff_b", 32'(VGA_B), 7);
    hold(2);
    check("gray_ffff_r3", 32'(VGA_R3), 7);
    pix(160, 120);
    hold(3);
    check("gray_f800_r", 32'(VGA_R), 1);
    check("gray_f800_b", 32'(VGA_B), 1);
    pix(162, 120);
    hold(3);
    check("gray_07e0_g", 32'(VGA_G), 4);

    // Single-cycle HS pulse latency
    VGAHS_in = 1'b0;
    step();
    VGAHS_in = 1'b1;
    check("hs_k1",  32'(VGAHS), 1);
    check("hs3_k1", 32'(VGAHS3), 1);
    for (int k = 2; k <= 6; k++) begin
      step();
      check($sformatf("hs_k%0d", k),  32'(VGAHS),  (k == 3) ? 32'd0 : 32'd1);
      check($sformatf("hs3_k%0d", k), 32'(VGAHS3), (k == 5) ? 32'd0 : 32'd1);
    end

    // Async reset mid-line
    pix(160, 120);
    VGAHS_in = 1'b0;
    hold(3);
    check("pre_rst_r",  32'(VGA_R), 1);
    check("pre_rst_hs", 32'(VGAHS), 0);
    rst_n = 1'b0;
    #1;
    check("arst_hs",    32'(VGAHS), 1);
    check("arst_r",     32'(VGA_R), 0);
    check("arst_rd_en", 32'(fb_rd_en), 0);
    check("arst_scale", 32'(scale_active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
